// File: rtl/sevenseg_scan_capture_if.sv
// Seven-segment scan bus as seen by the capture monitor:
// raw active-low pins in, reassembled frame word and link status out.
interface sevenseg_scan_capture_if;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] word;
    logic        word_valid;
    logic        word_err;
    logic        link_up;
    logic [7:0]  err_count;

    modport master (
        output seg_in, an_in,
        input  word, word_valid, word_err, link_up, err_count
    );

    modport slave (
        input  seg_in, an_in,
        output word, word_valid, word_err, link_up, err_count
    );
endinterface

// File: rtl/sevenseg_scan_capture.sv
// Samples a multiplexed 4-digit seven-segment bus, debounces each digit,
// decodes it back to hex and emits one 16-bit word per complete scan frame.
module sevenseg_scan_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    sevenseg_scan_capture_if.slave bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

    typedef enum logic {NO_LINK, LINKED} state_t;

    logic [10:0]      sync1_q, sync2_q, prev_q;
    logic [SW-1:0]    stab_q, stab_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic [3:0][3:0]  nib_q, nib_d;
    logic [3:0]       bad_q, bad_d;
    logic [3:0]       seen_q, seen_d;
    logic [15:0]      word_q, word_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic [7:0]       errcnt_q, errcnt_d;
    state_t           state_q, state_d;

    logic [3:0]       sel;
    logic [4:0]       dec;
    logic             same, acc;

    // {bad, nibble}; unknown patterns decode to 0 with bad set
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40: decode = 5'h00;
            7'h79: decode = 5'h01;
            7'h24: decode = 5'h02;
            7'h30: decode = 5'h03;
            7'h19: decode = 5'h04;
            7'h12: decode = 5'h05;
            7'h02: decode = 5'h06;
            7'h78: decode = 5'h07;
            7'h00: decode = 5'h08;
            7'h10: decode = 5'h09;
            7'h08: decode = 5'h0A;
            7'h03: decode = 5'h0B;
            7'h46: decode = 5'h0C;
            7'h21: decode = 5'h0D;
            7'h06: decode = 5'h0E;
            7'h0E: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    assign sel  = ~sync2_q[10:7];
    assign dec  = decode(sync2_q[6:0]);
    assign same = (sync2_q == prev_q);
    // fires once, on the edge where the hold count reaches its limit
    assign acc  = same && (stab_q == STAB_PRE) && $onehot(sel);

    always_comb begin
        stab_d   = '0;
        idle_d   = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;
        nib_d    = nib_q;
        bad_d    = bad_q;
        seen_d   = seen_q;
        word_d   = word_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        errcnt_d = errcnt_q;
        state_d  = state_q;
        if (same)
            stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
        if (acc) begin
            idle_d  = '0;
            state_d = LINKED;
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    nib_d[i] = dec[3:0];
                    bad_d[i] = dec[4];
                end
            end
            seen_d = seen_q | sel;
            if (seen_d == 4'hF) begin
                word_d  = nib_d;
                err_d   = |bad_d;
                valid_d = 1'b1;
                seen_d  = '0;
                bad_d   = '0;
                if (err_d && errcnt_q != 8'hFF)
                    errcnt_d = errcnt_q + 8'd1;
            end
        end else if (state_q == LINKED && idle_d == IDLE_MAX) begin
            state_d = NO_LINK;
            seen_d  = '0;
            bad_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 11'h7FF;
            sync2_q  <= 11'h7FF;
            prev_q   <= 11'h7FF;
            stab_q   <= '0;
            idle_q   <= '0;
            nib_q    <= '0;
            bad_q    <= '0;
            seen_q   <= '0;
            word_q   <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            errcnt_q <= '0;
            state_q  <= NO_LINK;
        end else begin
            sync1_q  <= {bus.an_in, bus.seg_in};
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            stab_q   <= stab_d;
            idle_q   <= idle_d;
            nib_q    <= nib_d;
            bad_q    <= bad_d;
            seen_q   <= seen_d;
            word_q   <= word_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            errcnt_q <= errcnt_d;
            state_q  <= state_d;
        end
    end

    assign bus.word       = word_q;
    assign bus.word_valid = valid_q;
    assign bus.word_err   = err_q;
    assign bus.link_up    = (state_q == LINKED);
    assign bus.err_count  = errcnt_q;
endmodule

// File: tb/tb_sevenseg_scan_capture.sv
// Directed bench for the seven-segment scan capture monitor
// (STABLE_CYCLES=4, TIMEOUT_CYCLES=64).
module tb_sevenseg_scan_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int vcount = 0;

    sevenseg_scan_capture_if bus();

    sevenseg_scan_capture #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.word_valid === 1'b1) vcount++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.an_in  = an;
        bus.seg_in = seg;
        tick(n);
    endtask

    task automatic scan(input logic [6:0] s0, s1, s2, s3, input int n);
        drive(4'hE, s0, n);
        drive(4'hD, s1, n);
        drive(4'hB, s2, n);
        drive(4'h7, s3, n);
    endtask

    task automatic test_reset;
        bus.an_in  = 4'hF;
        bus.seg_in = 7'h7F;
        rst = 1'b1;
        tick(2);
        checks++;
        if (bus.word !== 16'h0) begin
            errors++; $display("FAIL reset_word got %h want 0000", bus.word);
        end
        checks++;
        if (bus.word_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", bus.word_valid);
        end
        checks++;
        if (bus.word_err !== 1'b0) begin
            errors++; $display("FAIL reset_err got %b want 0", bus.word_err);
        end
        checks++;
        if (bus.link_up !== 1'b0) begin
            errors++; $display("FAIL reset_link got %b want 0", bus.link_up);
        end
        checks++;
        if (bus.err_count !== 8'd0) begin
            errors++; $display("FAIL reset_errcnt got %0d want 0", bus.err_count);
        end
        rst = 1'b0;
        tick(8);
        checks++;
        if (bus.link_up !== 1'b0) begin
            errors++; $display("FAIL blank_no_link got %b want 0", bus.link_up);
        end
    endtask

    task automatic test_frame;
        int v0;
        v0 = vcount;
        drive(4'hE, 7'h19, 6);
        checks++;
        if (bus.link_up !== 1'b0) begin
            errors++; $display("FAIL link_early got %b want 0", bus.link_up);
        end
        tick(1);
        checks++;
        if (bus.link_up !== 1'b1) begin
            errors++; $display("FAIL link_rise got %b want 1", bus.link_up);
        end
        tick(3);
        drive(4'hD, 7'h30, 10);
        drive(4'hB, 7'h24, 10);
        drive(4'h7, 7'h79, 6);
        checks++;
        if (bus.word_valid !== 1'b0) begin
            errors++; $display("FAIL valid_early got %b want 0", bus.word_valid);
        end
        tick(1);
        checks++;
        if (bus.word_valid !== 1'b1) begin
            errors++; $display("FAIL valid_edge7 got %b want 1", bus.word_valid);
        end
        checks++;
        if (bus.word !== 16'h1234) begin
            errors++; $display("FAIL frame_word got %h want 1234", bus.word);
        end
        checks++;
        if (bus.word_err !== 1'b0) begin
            errors++; $display("FAIL frame_err got %b want 0", bus.word_err);
        end
        tick(1);
        checks++;
        if (bus.word_valid !== 1'b0) begin
            errors++; $display("FAIL valid_pulse_len got %b want 0", bus.word_valid);
        end
        tick(2);
        checks++;
        if (vcount - v0 !== 1) begin
            errors++; $display("FAIL frame_pulses got %0d want 1", vcount - v0);
        end
    endtask

    task automatic test_glitch;
        int v0;
        v0 = vcount;
        drive(4'hE, 7'h19, 10);
        drive(4'hD, 7'h30, 3);
        drive(4'hD, 7'h00, 2);
        drive(4'hD, 7'h30, 10);
        drive(4'hB, 7'h24, 10);
        drive(4'h7, 7'h79, 10);
        checks++;
        if (vcount - v0 !== 1) begin
            errors++; $display("FAIL glitch_pulses got %0d want 1", vcount - v0);
        end
        checks++;
        if (bus.word !== 16'h1234) begin
            errors++; $display("FAIL glitch_word got %h want 1234", bus.word);
        end
        checks++;
        if (bus.word_err !== 1'b0) begin
            errors++; $display("FAIL glitch_err got %b want 0", bus.word_err);
        end
    endtask

    task automatic test_bad_frame;
        scan(7'h19, 7'h30, 7'h7F, 7'h79, 10);
        checks++;
        if (bus.word !== 16'h1034) begin
            errors++; $display("FAIL bad_word got %h want 1034", bus.word);
        end
        checks++;
        if (bus.word_err !== 1'b1) begin
            errors++; $display("FAIL bad_err got %b want 1", bus.word_err);
        end
        checks++;
        if (bus.err_count !== 8'd1) begin
            errors++; $display("FAIL bad_errcnt got %0d want 1", bus.err_count);
        end
        scan(7'h40, 7'h79, 7'h24, 7'h30, 10);
        checks++;
        if (bus.word !== 16'h3210) begin
            errors++; $display("FAIL clean_word got %h want 3210", bus.word);
        end
        checks++;
        if (bus.word_err !== 1'b0) begin
            errors++; $display("FAIL clean_err got %b want 0", bus.word_err);
        end
        checks++;
        if (bus.err_count !== 8'd1) begin
            errors++; $display("FAIL clean_errcnt got %0d want 1", bus.err_count);
        end
    endtask

    task automatic test_err_saturate;
        for (int i = 0; i < 253; i++)
            scan(7'h40, 7'h55, 7'h40, 7'h40, 8);
        checks++;
        if (bus.err_count !== 8'd254) begin
            errors++; $display("FAIL errcnt_254 got %0d want 254", bus.err_count);
        end
        for (int i = 0; i < 3; i++)
            scan(7'h40, 7'h55, 7'h40, 7'h40, 8);
        checks++;
        if (bus.err_count !== 8'd255) begin
            errors++; $display("FAIL errcnt_sat got %0d want 255", bus.err_count);
        end
    endtask

    task automatic test_link_loss;
        int v0;
        drive(4'hE, 7'h06, 10);
        drive(4'hD, 7'h0E, 10);
        drive(4'hF, 7'h7F, 60);
        checks++;
        if (bus.link_up !== 1'b1) begin
            errors++; $display("FAIL link_hold got %b want 1", bus.link_up);
        end
        tick(1);
        checks++;
        if (bus.link_up !== 1'b0) begin
            errors++; $display("FAIL link_timeout got %b want 0", bus.link_up);
        end
        tick(3);
        v0 = vcount;
        drive(4'hB, 7'h46, 10);
        drive(4'h7, 7'h21, 10);
        checks++;
        if (vcount - v0 !== 0) begin
            errors++; $display("FAIL seen_cleared got %0d want 0", vcount - v0);
        end
        checks++;
        if (bus.link_up !== 1'b1) begin
            errors++; $display("FAIL link_resume got %b want 1", bus.link_up);
        end
        drive(4'hE, 7'h08, 10);
        drive(4'hD, 7'h03, 10);
        checks++;
        if (vcount - v0 !== 1) begin
            errors++; $display("FAIL resume_pulses got %0d want 1", vcount - v0);
        end
        checks++;
        if (bus.word !== 16'hDCBA) begin
            errors++; $display("FAIL resume_word got %h want dcba", bus.word);
        end
    endtask

    task automatic test_multi_low;
        int v0;
        v0 = vcount;
        drive(4'b1100, 7'h40, 20);
        checks++;
        if (vcount - v0 !== 0) begin
            errors++; $display("FAIL multi_low_valid got %0d want 0", vcount - v0);
        end
        tick(40);
        checks++;
        if (bus.link_up !== 1'b1) begin
            errors++; $display("FAIL multi_low_link got %b want 1", bus.link_up);
        end
        tick(1);
        checks++;
        if (bus.link_up !== 1'b0) begin
            errors++; $display("FAIL multi_low_idle got %b want 0", bus.link_up);
        end
    endtask

    task automatic test_async_reset;
        int v0;
        scan(7'h19, 7'h30, 7'h24, 7'h79, 10);
        checks++;
        if (bus.word !== 16'h1234) begin
            errors++; $display("FAIL pre_rst_word got %h want 1234", bus.word);
        end
        drive(4'hE, 7'h19, 10);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.word !== 16'h0) begin
            errors++; $display("FAIL arst_word got %h want 0000", bus.word);
        end
        checks++;
        if (bus.word_valid !== 1'b0) begin
            errors++; $display("FAIL arst_valid got %b want 0", bus.word_valid);
        end
        checks++;
        if (bus.link_up !== 1'b0) begin
            errors++; $display("FAIL arst_link got %b want 0", bus.link_up);
        end
        checks++;
        if (bus.err_count !== 8'd0) begin
            errors++; $display("FAIL arst_errcnt got %0d want 0", bus.err_count);
        end
        bus.an_in  = 4'hF;
        bus.seg_in = 7'h7F;
        tick(2);
        rst = 1'b0;
        v0 = vcount;
        drive(4'hD, 7'h30, 10);
        drive(4'hB, 7'h24, 10);
        drive(4'h7, 7'h79, 10);
        checks++;
        if (vcount - v0 !== 0) begin
            errors++; $display("FAIL partial_discard got %0d want 0", vcount - v0);
        end
        drive(4'hE, 7'h19, 10);
        checks++;
        if (vcount - v0 !== 1) begin
            errors++; $display("FAIL post_rst_pulses got %0d want 1", vcount - v0);
        end
        checks++;
        if (bus.word !== 16'h1234) begin
            errors++; $display("FAIL post_rst_word got %h want 1234", bus.word);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_glitch();
        test_bad_frame();
        test_err_saturate();
        test_link_loss();
        test_multi_low();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
